// File: rtl/udcounter_sequencer.sv
// Initiator-side sequencer for a preset/up-down counter: presets it, counts it down to zero,
// parks it in hold, and cross-checks the counter's carry outputs against a private shadow count.
module udcounter_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] count_in,
  input  logic             abort,
  output logic [1:0]       ctr_mode,
  output logic [WIDTH-1:0] ctr_preset,
  input  logic             ctr_cout,
  input  logic             ctr_clout,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COUNT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [1:0]       MODE_PRESET = 2'b00;
  localparam logic [1:0]       MODE_DOWN   = 2'b01;
  localparam logic [1:0]       MODE_HOLD   = 2'b11;
  localparam logic [WIDTH-1:0] ZERO        = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] shadow_r, shadow_nxt_s;
  logic [WIDTH-1:0] preset_r, preset_nxt_s;
  logic [1:0]       mode_r, mode_nxt_s;
  logic             primed_r, primed_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             aborted_r, aborted_nxt_s;
  logic             err_r, err_nxt_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; abort only cancels while the counter is being loaded or counted
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = LOAD;
        else       state_nxt_s = IDLE;
      end
      LOAD: begin
        if (abort)                 state_nxt_s = IDLE;
        else if (shadow_r == ZERO) state_nxt_s = FINISH;
        else                       state_nxt_s = COUNT;
      end
      COUNT: begin
        if (abort)                state_nxt_s = IDLE;
        else if (shadow_r == ONE) state_nxt_s = FINISH;
        else                      state_nxt_s = COUNT;
      end
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the shadow datapath
  always_comb begin
    mode_nxt_s    = mode_r;
    preset_nxt_s  = preset_r;
    shadow_nxt_s  = shadow_r;
    primed_nxt_s  = primed_r;
    busy_nxt_s    = busy_r;
    err_nxt_s     = err_r;
    done_nxt_s    = 1'b0;
    aborted_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          mode_nxt_s   = MODE_PRESET;
          preset_nxt_s = count_in;
          shadow_nxt_s = count_in;
          busy_nxt_s   = 1'b1;
          err_nxt_s    = 1'b0;
          primed_nxt_s = 1'b0;
        end else begin
          mode_nxt_s = MODE_HOLD;
        end
      end
      LOAD: begin
        if (abort) begin
          mode_nxt_s    = MODE_HOLD;
          busy_nxt_s    = 1'b0;
          aborted_nxt_s = 1'b1;
        end else if (shadow_r == ZERO) begin
          mode_nxt_s = MODE_HOLD;
        end else begin
          mode_nxt_s = MODE_DOWN;
        end
      end
      COUNT: begin
        if (abort) begin
          mode_nxt_s    = MODE_HOLD;
          busy_nxt_s    = 1'b0;
          aborted_nxt_s = 1'b1;
        end else begin
          if (shadow_r != ZERO) shadow_nxt_s = shadow_r - ONE;
          else                  shadow_nxt_s = shadow_r;
          primed_nxt_s = 1'b1;
          // clout is stale on the first edge after a preset, so primed gates the check
          if (primed_r && (ctr_clout != (shadow_r == ONE))) err_nxt_s = 1'b1;
          else                                              err_nxt_s = err_r;
          if (shadow_r == ONE) mode_nxt_s = MODE_HOLD;
          else                 mode_nxt_s = MODE_DOWN;
        end
      end
      FINISH: begin
        mode_nxt_s = MODE_HOLD;
        if ((preset_r != ZERO) && !ctr_cout) err_nxt_s = 1'b1;
        else                                 err_nxt_s = err_r;
        done_nxt_s = 1'b1;
        busy_nxt_s = 1'b0;
      end
      default: begin
        mode_nxt_s = MODE_HOLD;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r    <= MODE_HOLD;
      preset_r  <= ZERO;
      shadow_r  <= ZERO;
      primed_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      mode_r    <= mode_nxt_s;
      preset_r  <= preset_nxt_s;
      shadow_r  <= shadow_nxt_s;
      primed_r  <= primed_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      aborted_r <= aborted_nxt_s;
      err_r     <= err_nxt_s;
    end
  end

  assign ctr_mode   = mode_r;
  assign ctr_preset = preset_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign aborted    = aborted_r;
  assign err        = err_r;

endmodule

// File: tb/tb_udcounter_sequencer.sv
// Directed bench for udcounter_sequencer with a behavioural preset/up-down counter attached.
module tb_udcounter_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [W-1:0] count_in;
  logic [1:0]   ctr_mode;
  logic [W-1:0] ctr_preset;
  logic         ctr_cout, ctr_clout;
  logic         busy, done, aborted, err;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural counter: 00 preset, 01 down, 10 up, 11 hold; cout pulses after a 1->0 step
  logic [W-1:0] cnt_out = 8'd0;
  logic         cnt_cout = 1'b0;
  int           down_edges = 0;
  logic         saw_up = 1'b0;
  logic         force_clout_low = 1'b0;

  udcounter_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .count_in(count_in), .abort(abort),
    .ctr_mode(ctr_mode), .ctr_preset(ctr_preset), .ctr_cout(ctr_cout), .ctr_clout(ctr_clout),
    .busy(busy), .done(done), .aborted(aborted), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      cnt_out  <= 8'd0;
      cnt_cout <= 1'b0;
    end else begin
      case (ctr_mode)
        2'b00: begin cnt_out <= ctr_preset; cnt_cout <= 1'b0; down_edges <= 0; end
        2'b01: begin cnt_out <= cnt_out - 8'd1; cnt_cout <= (cnt_out == 8'd1); down_edges <= down_edges + 1; end
        2'b10: begin cnt_out <= cnt_out + 8'd1; cnt_cout <= 1'b0; saw_up <= 1'b1; end
        default: cnt_cout <= 1'b0;
      endcase
    end
  end

  assign ctr_clout = (cnt_out == 8'd1) && (ctr_mode == 2'b01) && !force_clout_low;
  assign ctr_cout  = cnt_cout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_mode_f(int n, int i);
    if (i == 0)      return 2'b00;
    else if (i <= n) return 2'b01;
    else             return 2'b11;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; count_in = 8'd0;
    tick(); tick();
    vectors++;
    if ({ctr_mode, ctr_preset, busy, done, aborted, err} !== {2'b11, 8'd0, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_state: got mode=%b preset=%0d b/d/a/e=%b%b%b%b required mode=11 preset=0 0000",
               ctr_mode, ctr_preset, busy, done, aborted, err);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if ({ctr_mode, busy, done} !== {2'b11, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_after_reset: got mode=%b busy=%b done=%b required 11 0 0", ctr_mode, busy, done);
    end
  endtask

  task automatic test_count_n(input int n);
    logic [W-1:0] exp_out;
    count_in = n[W-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    count_in = 8'hA5;
    for (int i = 0; i <= n + 1; i++) begin
      vectors++;
      if (ctr_mode !== exp_mode_f(n, i)) begin
        miscompares++;
        $display("FAIL count%0d_mode[%0d]: got %b required %b", n, i, ctr_mode, exp_mode_f(n, i));
      end
      vectors++;
      if ({busy, done, aborted} !== 3'b100) begin
        miscompares++;
        $display("FAIL count%0d_flags[%0d]: got b/d/a=%b%b%b required 100", n, i, busy, done, aborted);
      end
      if (i >= 1) begin
        exp_out = W'(n - i + 1);
        vectors++;
        if (cnt_out !== exp_out) begin
          miscompares++;
          $display("FAIL count%0d_out[%0d]: got %0d required %0d", n, i, cnt_out, exp_out);
        end
      end
      tick();
    end
    vectors++;
    if ({done, busy, err, ctr_mode} !== {1'b1, 1'b0, 1'b0, 2'b11}) begin
      miscompares++;
      $display("FAIL count%0d_done: got d/b/e=%b%b%b mode=%b required 100 mode=11", n, done, busy, err, ctr_mode);
    end
    vectors++;
    if (cnt_out !== 8'd0 || down_edges != n || ctr_preset !== n[W-1:0]) begin
      miscompares++;
      $display("FAIL count%0d_final: got out=%0d down_edges=%0d preset=%0d required 0 %0d %0d",
               n, cnt_out, down_edges, ctr_preset, n, n);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || cnt_out !== 8'd0) begin
      miscompares++;
      $display("FAIL count%0d_after: got done=%b out=%0d required 0 0", n, done, cnt_out);
    end
  endtask

  task automatic test_start_while_busy();
    count_in = 8'd2;
    start = 1'b1;
    tick();
    count_in = 8'd7;
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (ctr_preset !== 8'd2 || done !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_start[%0d]: got preset=%0d done=%b busy=%b required 2 0 1", i, ctr_preset, done, busy);
      end
    end
    tick();
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || down_edges != 2 || cnt_out !== 8'd0) begin
      miscompares++;
      $display("FAIL busy_start_done: got done=%b down_edges=%0d out=%0d required 1 2 0", done, down_edges, cnt_out);
    end
    tick();
    vectors++;
    if (ctr_mode !== 2'b11 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_idle: got mode=%b busy=%b required 11 0", ctr_mode, busy);
    end
  endtask

  task automatic test_abort();
    int k;
    count_in = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (cnt_out !== 8'd3) begin
      miscompares++;
      $display("FAIL abort_pre: got out=%0d required 3", cnt_out);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if ({ctr_mode, busy, aborted, done} !== {2'b11, 1'b0, 1'b1, 1'b0} || cnt_out !== 8'd2) begin
      miscompares++;
      $display("FAIL abort_edge: got mode=%b b/a/d=%b%b%b out=%0d required 11 010 2",
               ctr_mode, busy, aborted, done, cnt_out);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || aborted !== 1'b0 || cnt_out !== 8'd2) begin
        miscompares++;
        $display("FAIL abort_hold[%0d]: got done=%b aborted=%b out=%0d required 0 0 2", i, done, aborted, cnt_out);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (aborted !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle_ignored: got aborted=%b busy=%b required 0 0", aborted, busy);
    end
    count_in = 8'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    vectors++;
    if ({ctr_mode, busy, aborted} !== {2'b00, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_vs_start: got mode=%b busy=%b aborted=%b required 00 1 0", ctr_mode, busy, aborted);
    end
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (done !== 1'b1 || aborted !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_finish_ignored: got done=%b aborted=%b err=%b required 1 0 0", done, aborted, err);
    end
    tick();
    count_in = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    vectors++;
    if (k != 4 || cnt_out !== 8'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_restart: got edges_to_done=%0d out=%0d err=%b required 4 0 0", k, cnt_out, err);
    end
    tick();
  endtask

  task automatic test_err_fault();
    force_clout_low = 1'b1;
    count_in = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_early: got err=%b required 0", err);
    end
    tick();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_detect: got err=%b required 1", err);
    end
    tick();
    force_clout_low = 1'b0;
    vectors++;
    if (done !== 1'b1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_done: got done=%b err=%b required 1 1", done, err);
    end
    tick(); tick();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_sticky: got err=%b required 1", err);
    end
    count_in = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_clear: got err=%b busy=%b required 0 1", err, busy);
    end
    tick(); tick(); tick();
    vectors++;
    if (done !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_clean_run: got done=%b err=%b required 1 0", done, err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int k;
    count_in = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    vectors++;
    if (k != 3) begin
      miscompares++;
      $display("FAIL b2b_first: got edges_to_done=%0d required 3", k);
    end
    count_in = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({ctr_mode, busy, done} !== {2'b00, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_accept: got mode=%b busy=%b done=%b required 00 1 0", ctr_mode, busy, done);
    end
    k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    vectors++;
    if (k != 4 || cnt_out !== 8'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: got edges_to_done=%0d out=%0d err=%b required 4 0 0", k, cnt_out, err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    count_in = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({ctr_mode, busy, done, aborted, err} !== {2'b11, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_mid: got mode=%b b/d/a/e=%b%b%b%b required 11 0000", ctr_mode, busy, done, aborted, err);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({ctr_mode, busy, done, aborted} !== {2'b11, 3'b000}) begin
        miscompares++;
        $display("FAIL reset_mid_idle[%0d]: got mode=%b b/d/a=%b%b%b required 11 000", i, ctr_mode, busy, done, aborted);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_count_n(3);
    test_count_n(0);
    test_count_n(1);
    test_start_while_busy();
    test_abort();
    test_err_fault();
    test_back_to_back();
    test_count_n(255);
    test_reset_mid();
    vectors++;
    if (saw_up !== 1'b0) begin
      miscompares++;
      $display("FAIL up_mode_seen: got %b required 0", saw_up);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
